// File: rtl/mac_fp32_conv_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_fp32_conv_sched_if
//  Description : Lane request bus and fp32 result bus of the converter
//                scheduler.
//                  i_req_vld / i_req_data / i_req_exp / o_req_rdy
//                    per-lane int34 requests with a one-hot grant
//                  o_res_vld / o_res_data / o_res_id / i_res_rdy
//                    fp32 result stream tagged with the producing lane
//                The slave modport is the scheduler side. The master modport
//                is the accumulator and writeback side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_fp32_conv_sched_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       i_req_vld;
    logic [N_REQ-1:0][33:0] i_req_data;
    logic [N_REQ-1:0][5:0]  i_req_exp;
    logic [N_REQ-1:0]       o_req_rdy;

    logic                   o_res_vld;
    logic [31:0]            o_res_data;
    logic [TAG_W-1:0]       o_res_id;
    logic                   i_res_rdy;

    modport slave (
        input  i_req_vld, i_req_data, i_req_exp, i_res_rdy,
        output o_req_rdy, o_res_vld, o_res_data, o_res_id
    );

    modport master (
        output i_req_vld, i_req_data, i_req_exp, i_res_rdy,
        input  o_req_rdy, o_res_vld, o_res_data, o_res_id
    );
endinterface
`default_nettype wire

// File: rtl/mac_fp32_conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mac_fp32_conv_sched
//  Description : Shares one mac_fp32_converter among N_REQ accumulator lanes.
//                A round-robin arbiter issues one int34 per cycle into the
//                converter's 2-stage pipeline. Issue is limited by credits, so
//                the converter never stalls. A lane tag travels alongside each
//                conversion. fp32 results are queued in a show-ahead FIFO.
//                Datatype reconfiguration waits until the pipeline is empty.
//  Ports       : i_clk, i_rst             clock, synchronous active-high reset
//                io_bus (slave)           lane requests and result stream
//                i_cfg_vld/i_cfg_*_dt     datatype change request
//                o_cfg_rdy                datatype change accepted this cycle
//                o_cvt_*                  converter controls and operands
//                i_cvt_data               converter fp32 output
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_fp32_conv_sched #(
    parameter int          N_REQ           = 4,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          TAG_W           = $clog2(N_REQ),
    parameter type         mac_datatype    = logic [1:0],
    parameter mac_datatype MAC_DATATYPE_I9 = mac_datatype'(0)
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    mac_fp32_conv_sched_if.slave  io_bus,
    input  wire logic             i_cfg_vld,
    input  wire mac_datatype      i_cfg_ifm_dt,
    input  wire mac_datatype      i_cfg_wfm_dt,
    output logic                  o_cfg_rdy,
    output mac_datatype           o_cvt_ifm_dt,
    output mac_datatype           o_cvt_wfm_dt,
    output logic [33:0]           o_cvt_intdata,
    output logic [5:0]            o_cvt_exp,
    output logic [1:0]            o_cvt_pipe_en,
    input  wire logic [31:0]      i_cvt_data
);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold fifo count plus the two pipeline valids.
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 3);

    logic [TAG_W-1:0]   r_ptr;
    logic               r_v1;
    logic               r_v2;
    logic [TAG_W-1:0]   r_tag1;
    logic [TAG_W-1:0]   r_tag2;
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [TAG_W-1:0]   r_fifo_id   [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    mac_datatype        r_ifm_dt;
    mac_datatype        r_wfm_dt;

    logic               w_any;
    logic [TAG_W-1:0]   w_grant;
    logic [TAG_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_sel;
    logic [TAG_W-1:0]   w_ptr_nxt;
    logic [c_CNT_W-1:0] w_used;
    logic               w_cred_ok;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;

    // Everything issued and not yet popped occupies a credit. A pop in this
    // cycle only frees its credit once r_cnt has been updated.
    assign w_used    = r_cnt + c_CNT_W'(r_v1) + c_CNT_W'(r_v2);
    assign w_cred_ok = (w_used < c_CNT_W'(FIFO_DEPTH));

    // First requesting lane at or after the round-robin pointer.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(r_ptr) + k >= N_REQ) begin
                w_idx = TAG_W'(int'(r_ptr) + k - N_REQ);
            end else begin
                w_idx = TAG_W'(int'(r_ptr) + k);
            end
            if (!w_any && io_bus.i_req_vld[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_issue   = w_any & w_cred_ok & ~i_cfg_vld & ~i_rst;
    assign w_sel     = w_issue ? w_grant : '0;
    assign w_ptr_nxt = (w_grant == TAG_W'(N_REQ - 1)) ? '0 : w_grant + TAG_W'(1);

    always_comb begin
        io_bus.o_req_rdy = '0;
        if (w_issue) begin
            io_bus.o_req_rdy[w_grant] = 1'b1;
        end
    end

    assign o_cvt_intdata = io_bus.i_req_data[w_sel];
    assign o_cvt_exp     = io_bus.i_req_exp[w_sel];
    assign o_cvt_pipe_en = {r_v1 & ~i_rst, w_issue};
    assign o_cvt_ifm_dt  = r_ifm_dt;
    assign o_cvt_wfm_dt  = r_wfm_dt;
    // A datatype change must not affect a conversion already in the pipeline.
    assign o_cfg_rdy     = i_cfg_vld & ~r_v1 & ~r_v2 & ~i_rst;

    // Converter output is valid during the cycle in which v2 is set.
    assign w_push = r_v2;
    assign w_pop  = io_bus.i_res_rdy & (r_cnt != '0);

    assign io_bus.o_res_vld  = (r_cnt != '0);
    assign io_bus.o_res_data = r_fifo_data[r_rd_ptr];
    assign io_bus.o_res_id   = r_fifo_id[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr    <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ifm_dt <= MAC_DATATYPE_I9;
            r_wfm_dt <= MAC_DATATYPE_I9;
        end else begin
            r_v1 <= w_issue;
            r_v2 <= r_v1;
            if (w_issue) begin
                r_ptr <= w_ptr_nxt;
            end
            if (o_cfg_rdy) begin
                r_ifm_dt <= i_cfg_ifm_dt;
                r_wfm_dt <= i_cfg_wfm_dt;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Tags and FIFO storage need no reset: they are only observed behind the
    // reset-cleared valids and count.
    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_tag1 <= w_grant;
        end
        r_tag2 <= r_tag1;
        if (w_push && !i_rst) begin
            r_fifo_data[r_wr_ptr] <= i_cvt_data;
            r_fifo_id[r_wr_ptr]   <= r_tag2;
        end
    end

    a_no_push_when_full : assert property (
        @(posedge i_clk) disable iff (i_rst)
        !(w_push && (r_cnt == c_CNT_W'(FIFO_DEPTH)))
    );

endmodule
`default_nettype wire

// File: tb/tb_mac_fp32_conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_fp32_conv_sched
//  Description : Directed and random bench for mac_fp32_conv_sched. Contains
//                a behavioural model of the shared converter and a reference
//                model of the scheduler. The scheduler model is expressed as a
//                queue of outstanding conversions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_fp32_conv_sched;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int TW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_vld;
    logic [1:0]  cfg_ifm;
    logic [1:0]  cfg_wfm;
    logic        cfg_rdy;
    logic [1:0]  cvt_ifm;
    logic [1:0]  cvt_wfm;
    logic [33:0] cvt_int;
    logic [5:0]  cvt_exp;
    logic [1:0]  pe;
    logic [31:0] cvt_data;

    always #5 clk = ~clk;

    mac_fp32_conv_sched_if #(.N_REQ(N), .TAG_W(TW)) bus ();

    mac_fp32_conv_sched #(.N_REQ(N), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .io_bus        (bus),
        .i_cfg_vld     (cfg_vld),
        .i_cfg_ifm_dt  (cfg_ifm),
        .i_cfg_wfm_dt  (cfg_wfm),
        .o_cfg_rdy     (cfg_rdy),
        .o_cvt_ifm_dt  (cvt_ifm),
        .o_cvt_wfm_dt  (cvt_wfm),
        .o_cvt_intdata (cvt_int),
        .o_cvt_exp     (cvt_exp),
        .o_cvt_pipe_en (pe),
        .i_cvt_data    (cvt_data)
    );

    // int34 * 2^-exp rounded to nearest-even fp32.
    function automatic logic [31:0] f32(input logic [33:0] v, input logic [5:0] e);
        logic        s;
        logic [33:0] mag;
        int          msb;
        int          sh;
        int          ex;
        longint      m;
        longint      rem;
        longint      half;
        if (v == 34'd0) return 32'h0;
        s   = v[33];
        mag = s ? (~v + 34'd1) : v;
        msb = 0;
        for (int i = 0; i < 34; i++) if (mag[i]) msb = i;
        if (msb <= 23) begin
            m = longint'(mag) << (23 - msb);
        end else begin
            sh   = msb - 23;
            m    = longint'(mag) >> sh;
            rem  = longint'(mag) & ((64'sd1 << sh) - 1);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 1;
            if (m == (64'sd1 << 24)) begin
                m   = m >> 1;
                msb = msb + 1;
            end
        end
        ex = 127 + msb - int'(e);
        return {s, ex[7:0], m[22:0]};
    endfunction

    // Converter: two enabled stages, data registers not reset.
    logic [31:0] s0;
    logic [31:0] s1;
    always @(posedge clk) begin
        if (pe[0]) s0 <= f32(cvt_int, cvt_exp);
        if (pe[1]) s1 <= s0;
    end
    assign cvt_data = s1;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          cyc;
    } ent_t;

    ent_t       q[$];
    int         mptr;
    bit         prev1;
    bit         prev2;
    logic [1:0] m_ifm;
    logic [1:0] m_wfm;
    int         now;
    int         vectors;
    int         miscompares;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs at the falling edge against the model, then update
    // the model for the coming rising edge.
    task automatic sample();
        logic [3:0] erdy;
        bit         evld;
        int         g;
        @(negedge clk);
        if (rst) begin
            check("rst_req_rdy", 64'(bus.o_req_rdy), 64'd0);
            check("rst_pipe_en", 64'(pe), 64'd0);
            check("rst_cfg_rdy", 64'(cfg_rdy), 64'd0);
            q.delete();
            mptr  = 0;
            prev1 = 1'b0;
            prev2 = 1'b0;
            m_ifm = 2'd0;
            m_wfm = 2'd0;
        end else begin
            erdy = 4'd0;
            g    = -1;
            if (bus.i_req_vld != 4'd0 && !cfg_vld && q.size() < D) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && bus.i_req_vld[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            if (g >= 0) erdy[g] = 1'b1;
            check("req_rdy", 64'(bus.o_req_rdy), 64'(erdy));
            check("pipe_en", 64'(pe), 64'({prev1, g >= 0}));
            check("cfg_rdy", 64'(cfg_rdy), 64'(cfg_vld && !prev1 && !prev2));
            check("ifm_dt", 64'(cvt_ifm), 64'(m_ifm));
            check("wfm_dt", 64'(cvt_wfm), 64'(m_wfm));
            evld = (q.size() > 0) && (q[0].cyc + 3 <= now);
            check("res_vld", 64'(bus.o_res_vld), 64'(evld));
            if (evld) begin
                check("res_id", 64'(bus.o_res_id), 64'(q[0].id));
                check("res_data", 64'(bus.o_res_data), 64'(q[0].data));
                if (bus.i_res_rdy) void'(q.pop_front());
            end
            if (g >= 0) begin
                q.push_back('{2'(g), f32(bus.i_req_data[g], bus.i_req_exp[g]), now});
                mptr = (g + 1) % N;
            end
            if (cfg_vld && !prev1 && !prev2) begin
                m_ifm = cfg_ifm;
                m_wfm = cfg_wfm;
            end
            prev2 = prev1;
            prev1 = (g >= 0);
        end
        now++;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    function automatic logic [33:0] rnd34();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return 34'h0;
            1:       return 34'h3FFFFFFFF;
            2:       return 34'h200000000;
            3:       return 34'h1FFFFFFFF;
            default: return t[33:0];
        endcase
    endfunction

    task automatic drain(input string tag);
        bus.i_req_vld = '0;
        cfg_vld       = 1'b0;
        bus.i_res_rdy = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        check(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int          grants;
        logic [31:0] head_d;
        logic [1:0]  head_id;
        vectors       = 0;
        miscompares   = 0;
        now           = 0;
        mptr          = 0;
        prev1         = 1'b0;
        prev2         = 1'b0;
        m_ifm         = 2'd0;
        m_wfm         = 2'd0;
        bus.i_req_vld  = '0;
        bus.i_req_data = '0;
        bus.i_req_exp  = '0;
        bus.i_res_rdy  = 1'b0;
        cfg_vld       = 1'b0;
        cfg_ifm       = 2'd0;
        cfg_wfm       = 2'd0;

        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        sample();
        check("post_rst_res_vld", 64'(bus.o_res_vld), 64'd0);
        check("post_rst_ifm_dt", 64'(cvt_ifm), 64'd0);
        advance();

        // Lane 0 alone, value 1.
        bus.i_res_rdy     = 1'b1;
        bus.i_req_data[0] = 34'h1;
        bus.i_req_exp[0]  = 6'd0;
        bus.i_req_vld     = 4'b0001;
        sample();
        check("t1_grant", 64'(bus.o_req_rdy), 64'h1);
        advance();
        bus.i_req_vld = '0;
        cycle();
        cycle();
        sample();
        check("t1_vld", 64'(bus.o_res_vld), 64'd1);
        check("t1_data", 64'(bus.o_res_data), 64'h3F800000);
        check("t1_id", 64'(bus.o_res_id), 64'd0);
        advance();
        drain("t1_drain");

        // All lanes every cycle, consumer always ready.
        bus.i_res_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int l = 0; l < N; l++) begin
                bus.i_req_data[l] = rnd34();
                bus.i_req_exp[l]  = 6'($urandom_range(0, 20));
            end
            bus.i_req_vld = 4'b1111;
            sample();
            check("t2_one_grant", 64'($countones(bus.o_req_rdy)), 64'd1);
            advance();
        end
        drain("t2_drain");

        // Consumer stalled: exactly D grants, head holds.
        bus.i_res_rdy = 1'b0;
        bus.i_req_vld = 4'b1111;
        grants        = 0;
        head_d        = '0;
        head_id       = '0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (bus.o_req_rdy != 4'd0) grants++;
            if (i == 4) begin
                head_d  = bus.o_res_data;
                head_id = bus.o_res_id;
            end
            advance();
        end
        sample();
        check("t3_grants", 64'(grants), 64'(D));
        check("t3_head_data", 64'(bus.o_res_data), 64'(head_d));
        check("t3_head_id", 64'(bus.o_res_id), 64'(head_id));
        advance();
        drain("t3_drain");

        // -1 on lane 2, then a datatype change behind it.
        bus.i_res_rdy     = 1'b1;
        bus.i_req_data[2] = 34'h3FFFFFFFF;
        bus.i_req_exp[2]  = 6'd0;
        bus.i_req_vld     = 4'b0100;
        sample();
        check("t4_grant", 64'(bus.o_req_rdy), 64'h4);
        advance();
        bus.i_req_vld = '0;
        cfg_vld       = 1'b1;
        cfg_ifm       = 2'd2;
        cfg_wfm       = 2'd3;
        sample();
        check("t4_cfg_wait1", 64'(cfg_rdy), 64'd0);
        advance();
        sample();
        check("t4_cfg_wait2", 64'(cfg_rdy), 64'd0);
        advance();
        sample();
        check("t4_cfg_acc", 64'(cfg_rdy), 64'd1);
        check("t4_vld", 64'(bus.o_res_vld), 64'd1);
        check("t4_id", 64'(bus.o_res_id), 64'd2);
        check("t4_data", 64'(bus.o_res_data), 64'hBF800000);
        advance();
        cfg_vld = 1'b0;
        sample();
        check("t4_ifm_dt", 64'(cvt_ifm), 64'd2);
        check("t4_wfm_dt", 64'(cvt_wfm), 64'd3);
        advance();
        drain("t4_drain");

        // Reset with both pipeline stages busy and two FIFO entries.
        bus.i_res_rdy = 1'b0;
        bus.i_req_vld = 4'b1111;
        repeat (4) cycle();
        bus.i_req_vld = '0;
        rst           = 1'b1;
        cycle();
        rst = 1'b0;
        sample();
        check("t5_res_vld", 64'(bus.o_res_vld), 64'd0);
        check("t5_pipe_en", 64'(pe), 64'd0);
        advance();
        bus.i_res_rdy = 1'b1;
        repeat (8) cycle();

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            for (int l = 0; l < N; l++) begin
                bus.i_req_data[l] = rnd34();
                bus.i_req_exp[l]  = 6'($urandom_range(0, 63));
            end
            bus.i_req_vld = 4'($urandom);
            bus.i_res_rdy = 1'($urandom);
            cfg_vld       = ($urandom_range(0, 15) == 0);
            cfg_ifm       = 2'($urandom);
            cfg_wfm       = 2'($urandom);
            cycle();
        end
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
